// File: rtl/piso_pkg.sv
// Shared types and default parameter values for the parallel-to-serial converter.
package piso_pkg;

   typedef enum logic {PS_IDLE, PS_SHIFT} piso_state_e;

   localparam int unsigned DEF_DATA_W    = 8;
   localparam int unsigned DEF_MSB_FIRST = 0;
   localparam logic        DEF_IDLE_LVL  = 1'b0;

endpackage

// File: rtl/piso_bit_cnt.sv
// Bit-position counter: synchronous load-to-zero, count enable, and a
// terminal-count flag at LAST. Counting past LAST wraps to zero explicitly.
module piso_bit_cnt
   import piso_pkg::*;
#(
   parameter int unsigned CNT_W = 3,
   parameter int unsigned LAST  = 7
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic en,
   output logic tc
);

   logic [CNT_W-1:0] cnt;

   assign tc = (cnt == CNT_W'(LAST));

   // Explicit wrap at LAST keeps non-power-of-2 word widths exact.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= tc ? '0 : cnt + 1'b1;
      end
   end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-to-serial converter: valid/ready word intake, one bit per i_tick,
// selectable bit order, last-bit flag and zero-bubble back-to-back words.
module piso_serializer
   import piso_pkg::*;
#(
   parameter int unsigned DATA_W    = DEF_DATA_W,
   parameter int unsigned MSB_FIRST = DEF_MSB_FIRST,
   parameter logic        IDLE_LVL  = DEF_IDLE_LVL
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic [DATA_W-1:0] i_pdata,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic              i_tick,
   input  logic              i_clr,
   output logic              o_sdata,
   output logic              o_sdata_vld,
   output logic              o_sync,
   output logic              o_busy
);

   localparam int unsigned CNT_W = $clog2(DATA_W);

   piso_state_e       state_q, state_d;
   logic [DATA_W-1:0] sreg_q, sreg_d;
   logic              sdata_q, sdata_d;
   logic              cnt_load, cnt_en, last;
   logic              accept, shifting;

   piso_bit_cnt #(
      .CNT_W (CNT_W),
      .LAST  (DATA_W - 1)
   ) u_bit_cnt (
      .clk   (i_clk),
      .rst_n (i_rst_n),
      .load  (cnt_load),
      .en    (cnt_en),
      .tc    (last)
   );

   assign shifting = (state_q == PS_SHIFT);
   assign o_ready  = !i_clr && (!shifting || (last && i_tick));
   assign accept   = i_valid && o_ready;

   always_comb begin
      state_d  = state_q;
      sreg_d   = sreg_q;
      cnt_load = 1'b0;
      cnt_en   = 1'b0;
      if (i_clr) begin
         state_d  = PS_IDLE;
         sreg_d   = '0;
         cnt_load = 1'b1;
      end else if (accept) begin
         // Also covers the final tick of a word: new word follows with no gap.
         state_d  = PS_SHIFT;
         sreg_d   = i_pdata;
         cnt_load = 1'b1;
      end else if (shifting && i_tick) begin
         cnt_en = 1'b1;
         if (last) begin
            state_d = PS_IDLE;
            sreg_d  = '0;
         end else if (MSB_FIRST != 0) begin
            sreg_d = sreg_q << 1;
         end else begin
            sreg_d = sreg_q >> 1;
         end
      end
   end

   // Output bit is registered from the next-state register image.
   always_comb begin
      sdata_d = IDLE_LVL;
      if (state_d == PS_SHIFT) begin
         sdata_d = (MSB_FIRST != 0) ? sreg_d[DATA_W-1] : sreg_d[0];
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= PS_IDLE;
         sreg_q  <= '0;
         sdata_q <= IDLE_LVL;
      end else begin
         state_q <= state_d;
         sreg_q  <= sreg_d;
         sdata_q <= sdata_d;
      end
   end

   assign o_sdata     = sdata_q;
   assign o_sdata_vld = shifting;
   assign o_busy      = shifting;
   assign o_sync      = shifting && last;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench: an 8-bit LSB-first instance (idle level 0) and a 12-bit
// MSB-first instance (idle level 1), checked against hand-computed bit streams.
module tb_piso_serializer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;

   logic [7:0]  pdata_a = '0;
   logic        valid_a = 1'b0, tick_a = 1'b0, clr_a = 1'b0;
   logic        ready_a, sdata_a, vld_a, sync_a, busy_a;

   logic [11:0] pdata_b = '0;
   logic        valid_b = 1'b0, tick_b = 1'b0, clr_b = 1'b0;
   logic        ready_b, sdata_b, vld_b, sync_b, busy_b;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   piso_serializer #(.DATA_W(8), .MSB_FIRST(0), .IDLE_LVL(1'b0)) dut_a (
      .i_clk(clk), .i_rst_n(rst_n), .i_pdata(pdata_a), .i_valid(valid_a),
      .o_ready(ready_a), .i_tick(tick_a), .i_clr(clr_a), .o_sdata(sdata_a),
      .o_sdata_vld(vld_a), .o_sync(sync_a), .o_busy(busy_a)
   );

   piso_serializer #(.DATA_W(12), .MSB_FIRST(1), .IDLE_LVL(1'b1)) dut_b (
      .i_clk(clk), .i_rst_n(rst_n), .i_pdata(pdata_b), .i_valid(valid_b),
      .o_ready(ready_b), .i_tick(tick_b), .i_clr(clr_b), .o_sdata(sdata_b),
      .o_sdata_vld(vld_b), .o_sync(sync_b), .o_busy(busy_b)
   );

   task automatic test_reset();
      #12;
      checks++;
      if ({sdata_a, vld_a, sync_a, busy_a} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_a: sdata/vld/sync/busy got %b exp 0000", {sdata_a, vld_a, sync_a, busy_a});
      end
      checks++;
      if ({sdata_b, vld_b, sync_b, busy_b} !== 4'b1000) begin
         errors++;
         $display("FAIL reset_b: sdata/vld/sync/busy got %b exp 1000", {sdata_b, vld_b, sync_b, busy_b});
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if ({ready_a, ready_b} !== 2'b11) begin
         errors++;
         $display("FAIL reset_ready: got %b exp 11", {ready_a, ready_b});
      end
   endtask

   task automatic test_lsb_a5();
      bit exp_seq [8] = '{1, 0, 1, 0, 0, 1, 0, 1};
      pdata_a = 8'hA5; valid_a = 1'b1; tick_a = 1'b1;
      #1;
      checks++;
      if (ready_a !== 1'b1) begin
         errors++;
         $display("FAIL a5_ready_idle: got %b exp 1", ready_a);
      end
      @(posedge clk);
      for (int i = 0; i < 8; i++) begin
         #1;
         if (i == 0) valid_a = 1'b0;
         checks++;
         if ({sdata_a, vld_a, sync_a} !== {exp_seq[i], 1'b1, (i == 7)}) begin
            errors++;
            $display("FAIL a5_bit%0d: sdata/vld/sync got %b exp %b", i, {sdata_a, vld_a, sync_a}, {exp_seq[i], 1'b1, (i == 7)});
         end
         #1;
         checks++;
         if (ready_a !== (i == 7)) begin
            errors++;
            $display("FAIL a5_ready%0d: got %b exp %b", i, ready_a, (i == 7));
         end
         @(posedge clk);
      end
      #1;
      checks++;
      if ({sdata_a, vld_a, sync_a, busy_a} !== 4'b0000) begin
         errors++;
         $display("FAIL a5_idle: sdata/vld/sync/busy got %b exp 0000", {sdata_a, vld_a, sync_a, busy_a});
      end
   endtask

   task automatic test_msb_c3a();
      bit exp_seq [12] = '{1, 1, 0, 0, 0, 0, 1, 1, 1, 0, 1, 0};
      pdata_b = 12'hC3A; valid_b = 1'b1; tick_b = 1'b1;
      #1;
      @(posedge clk);
      for (int i = 0; i < 12; i++) begin
         #1;
         if (i == 0) valid_b = 1'b0;
         checks++;
         if ({sdata_b, vld_b, sync_b} !== {exp_seq[i], 1'b1, (i == 11)}) begin
            errors++;
            $display("FAIL c3a_bit%0d: sdata/vld/sync got %b exp %b", i, {sdata_b, vld_b, sync_b}, {exp_seq[i], 1'b1, (i == 11)});
         end
         @(posedge clk);
      end
      #1;
      checks++;
      if ({sdata_b, vld_b, busy_b} !== 3'b100) begin
         errors++;
         $display("FAIL c3a_idle: sdata/vld/busy got %b exp 100", {sdata_b, vld_b, busy_b});
      end
   endtask

   task automatic test_slow_tick();
      bit exp_seq [8] = '{1, 0, 0, 0, 0, 0, 0, 1};
      pdata_a = 8'h81; valid_a = 1'b1; tick_a = 1'b0;
      #1;
      @(posedge clk);
      for (int c = 0; c < 32; c++) begin
         #1;
         if (c == 0) valid_a = 1'b0;
         checks++;
         if ({sdata_a, vld_a, sync_a} !== {exp_seq[c/4], 1'b1, (c >= 28)}) begin
            errors++;
            $display("FAIL slow_cyc%0d: sdata/vld/sync got %b exp %b", c, {sdata_a, vld_a, sync_a}, {exp_seq[c/4], 1'b1, (c >= 28)});
         end
         tick_a = (c % 4 == 3);
         #1;
         checks++;
         if (ready_a !== (c == 31)) begin
            errors++;
            $display("FAIL slow_ready%0d: got %b exp %b", c, ready_a, (c == 31));
         end
         @(posedge clk);
      end
      #1;
      checks++;
      if ({sdata_a, vld_a} !== 2'b00) begin
         errors++;
         $display("FAIL slow_idle: sdata/vld got %b exp 00", {sdata_a, vld_a});
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] words [3] = '{8'h01, 8'hFF, 8'h80};
      pdata_a = words[0]; valid_a = 1'b1; tick_a = 1'b1;
      #1;
      @(posedge clk);
      for (int c = 0; c < 24; c++) begin
         int b;
         int w;
         b = c % 8;
         w = c / 8;
         #1;
         checks++;
         if ({sdata_a, vld_a, sync_a} !== {words[w][b], 1'b1, (b == 7)}) begin
            errors++;
            $display("FAIL b2b_bit%0d: sdata/vld/sync got %b exp %b", c, {sdata_a, vld_a, sync_a}, {words[w][b], 1'b1, (b == 7)});
         end
         if (b == 7) begin
            if (w < 2) pdata_a = words[w+1];
            else valid_a = 1'b0;
         end
         #1;
         checks++;
         if (ready_a !== (b == 7)) begin
            errors++;
            $display("FAIL b2b_ready%0d: got %b exp %b", c, ready_a, (b == 7));
         end
         @(posedge clk);
      end
      #1;
      checks++;
      if ({vld_a, busy_a} !== 2'b00) begin
         errors++;
         $display("FAIL b2b_idle: vld/busy got %b exp 00", {vld_a, busy_a});
      end
   endtask

   task automatic test_clear();
      bit pre_seq [3] = '{0, 0, 1};
      bit exp_seq [8] = '{0, 1, 0, 1, 1, 0, 1, 0};
      pdata_a = 8'h3C; valid_a = 1'b1; tick_a = 1'b1;
      #1;
      @(posedge clk);
      for (int c = 0; c < 3; c++) begin
         #1;
         if (c == 0) valid_a = 1'b0;
         checks++;
         if ({sdata_a, vld_a} !== {pre_seq[c], 1'b1}) begin
            errors++;
            $display("FAIL clr_pre%0d: sdata/vld got %b exp %b", c, {sdata_a, vld_a}, {pre_seq[c], 1'b1});
         end
         if (c == 2) begin
            clr_a = 1'b1; valid_a = 1'b1; pdata_a = 8'h5A;
         end
         #1;
         checks++;
         if (ready_a !== 1'b0) begin
            errors++;
            $display("FAIL clr_ready%0d: got %b exp 0", c, ready_a);
         end
         @(posedge clk);
      end
      #1;
      checks++;
      if ({sdata_a, vld_a, sync_a, busy_a} !== 4'b0000) begin
         errors++;
         $display("FAIL clr_idle: sdata/vld/sync/busy got %b exp 0000", {sdata_a, vld_a, sync_a, busy_a});
      end
      clr_a = 1'b0;
      #1;
      checks++;
      if (ready_a !== 1'b1) begin
         errors++;
         $display("FAIL clr_ready_after: got %b exp 1", ready_a);
      end
      @(posedge clk);
      for (int i = 0; i < 8; i++) begin
         #1;
         if (i == 0) valid_a = 1'b0;
         checks++;
         if ({sdata_a, vld_a, sync_a} !== {exp_seq[i], 1'b1, (i == 7)}) begin
            errors++;
            $display("FAIL clr_5a_bit%0d: sdata/vld/sync got %b exp %b", i, {sdata_a, vld_a, sync_a}, {exp_seq[i], 1'b1, (i == 7)});
         end
         @(posedge clk);
      end
      #1;
      checks++;
      if (vld_a !== 1'b0) begin
         errors++;
         $display("FAIL clr_5a_idle: vld got %b exp 0", vld_a);
      end
   endtask

   task automatic test_async_reset();
      pdata_a = 8'hFF; valid_a = 1'b1; tick_a = 1'b1;
      #1;
      @(posedge clk);
      #1;
      valid_a = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #3;
      checks++;
      if ({sdata_a, vld_a} !== 2'b11) begin
         errors++;
         $display("FAIL arst_pre: sdata/vld got %b exp 11", {sdata_a, vld_a});
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({sdata_a, vld_a, sync_a, busy_a} !== 4'b0000) begin
         errors++;
         $display("FAIL arst_a: sdata/vld/sync/busy got %b exp 0000", {sdata_a, vld_a, sync_a, busy_a});
      end
      checks++;
      if ({sdata_b, vld_b} !== 2'b10) begin
         errors++;
         $display("FAIL arst_b: sdata/vld got %b exp 10", {sdata_b, vld_b});
      end
      #3;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if ({ready_a, vld_a, sdata_a} !== 3'b100) begin
         errors++;
         $display("FAIL arst_release: ready/vld/sdata got %b exp 100", {ready_a, vld_a, sdata_a});
      end
   endtask

   initial begin
      test_reset();
      test_lsb_a5();
      test_msb_c3a();
      test_slow_tick();
      test_back_to_back();
      test_clear();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
